im_stream_loader: RTL and testbench

- Writer side of the instruction memory: receives a byte stream, assembles 32-bit big-endian MIPS words and writes them sequentially into the instruction memory through a word-addressed write port.
- Sits between a byte source (UART receiver or testbench) and the instruction memory write port.
- Holds the CPU in reset while loading.
- Replaces file-based preload for hardware bring-up.

---
 rtl/im_stream_loader_pkg.sv | 18 +
 rtl/im_word_assembler.sv | 45 ++++
 rtl/im_stream_loader.sv | 167 ++++++++++++++++
 tb/tb_im_stream_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/im_stream_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader.
// Frame layout: 2 big-endian length bytes, then big-endian 32-bit words.
package im_stream_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_e;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_word_assembler.sv
// Shifts stream bytes into a big-endian word and flags the byte that completes it.
// word_next presents the full word combinationally alongside word_complete.
module im_word_assembler
    import im_stream_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_complete
);

    localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);

    // Only the three earlier bytes need storage; the fourth arrives on byte_in.
    logic [23:0]     word_q, word_d;
    logic [IdxW-1:0] idx_q, idx_d;

    always_comb begin
        word_next     = {word_q, byte_in};
        word_complete = shift_en && (idx_q == IdxW'(BYTES_PER_WORD - 1));
        word_d        = word_q;
        idx_d         = idx_q;
        if (clr) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shift_en) begin
            word_d = word_next[23:0];
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/im_stream_loader.sv
// Loads a length-prefixed byte stream into instruction memory, one word per
// WRITE cycle, holding busy high so the CPU stays in reset meanwhile.
module im_stream_loader
    import im_stream_loader_pkg::*;
#(
    parameter int unsigned AddrWidth     = 10,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ready,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AddrWidth:0]   words_written
);

    localparam int unsigned LenW     = 8 * LEN_BYTES;
    localparam int unsigned Capacity = 1 << AddrWidth;

    state_e               state_q, state_d;
    logic [LenW-1:0]      len_q, len_d, len_full;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth:0]   words_q, words_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          tmo_q, tmo_d;
    logic                 done_q, done_d, err_q, err_d;
    logic                 xfer, asm_clr, shift_en, word_complete;
    logic [31:0]          word_next;

    assign xfer = rx_valid && rx_ready;

    im_word_assembler u_asm (
        .clk           (clk),
        .rst           (rst),
        .clr           (asm_clr),
        .shift_en      (shift_en),
        .byte_in       (rx_data),
        .word_next     (word_next),
        .word_complete (word_complete)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        words_d  = words_q;
        wdata_d  = wdata_q;
        tmo_d    = tmo_q;
        done_d   = done_q;
        err_d    = err_q;
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        asm_clr  = 1'b0;
        shift_en = 1'b0;
        len_full = {len_q[LenW-9:0], rx_data};

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    addr_d  = '0;
                    tmo_d   = '0;
                    asm_clr = 1'b1;
                end
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    len_d   = len_full;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (32'(len_full) > Capacity) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                shift_en = xfer;
                if (word_complete) begin
                    wdata_d = word_next;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we  = 1'b1;
                busy    = 1'b1;
                addr_d  = addr_q + 1'b1;
                words_d = words_q + 1'b1;
                if (32'(words_d) == 32'(len_q)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end
            default: state_d = IDLE;
        endcase

        // Idle-gap watchdog; rx_ready is high exactly in the states it guards.
        if (TimeoutCycles != 0 && rx_ready) begin
            if (xfer) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_d == TimeoutCycles) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            words_q <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_im_stream_loader.sv
// Self-checking bench for im_stream_loader: length-field table, byte-level
// corner sequences, and randomized loads checked against an expected-word list.
module tb_im_stream_loader;

    localparam int unsigned AW = 10;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst, start, rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready, mem_we, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   words_written;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    im_stream_loader #(.AddrWidth(AW), .TimeoutCycles(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    // Memory-side observer: every write strobe, and every stalled valid byte while busy.
    wr_t wq[$];
    int  ready_drops = 0;
    always @(negedge clk) begin
        if (mem_we) wq.push_back('{mem_addr, mem_wdata});
        if (busy && rx_valid && !rx_ready) ready_drops++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        k = 0;
        while (!rx_ready && k < 50) begin @(posedge clk); #1; k++; end
        if (!rx_ready) chk("rx_ready_wait", 64'(rx_ready), 64'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && !err && k < 20) begin @(posedge clk); #1; k++; end
    endtask

    task automatic check_writes(input int base, input logic [31:0] exp[$]);
        int got;
        got = wq.size() - base;
        chk("write_count", 64'(got), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got; i++) begin
            chk("write_addr", 64'(wq[base + i].a), 64'(i));
            chk("write_data", 64'(wq[base + i].d), 64'(exp[i]));
        end
    endtask

    // Reference: a load of n random words must write word i to address i in order.
    task automatic run_load(input int n, input int maxgap, input bit poke);
        logic [31:0] exp[$];
        logic [15:0] nl;
        int          base;
        base = wq.size();
        nl   = 16'(n);
        for (int i = 0; i < n; i++) exp.push_back($urandom);
        do_start();
        send_byte(nl[15:8], 0);
        if (poke) do_start();
        send_byte(nl[7:0], $urandom_range(maxgap, 0));
        for (int i = 0; i < n; i++)
            for (int b = 3; b >= 0; b--)
                send_byte(exp[i][8*b +: 8], $urandom_range(maxgap, 0));
        wait_done();
        chk("load_done", 64'(done), 64'd1);
        chk("load_err", 64'(err), 64'd0);
        chk("load_busy", 64'(busy), 64'd0);
        chk("load_words", 64'(words_written), 64'(n));
        check_writes(base, exp);
    endtask

    typedef struct {
        logic [15:0] len;
        logic        exp_done;
        logic        exp_err;
    } lvec_t;

    initial begin
        lvec_t       lt[4];
        logic [7:0]  ex[10];
        logic [31:0] exw[$];
        int          base, drops0;

        lt[0] = '{16'h0000, 1'b1, 1'b0};
        lt[1] = '{16'h0401, 1'b0, 1'b1};
        lt[2] = '{16'hFFFF, 1'b0, 1'b1};
        lt[3] = '{16'h0800, 1'b0, 1'b1};
        ex = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h21, 8'h09, 8'h00, 8'h02};

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #1;
        chk("reset_outputs", 64'({rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_written}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Length-field outcomes with no data bytes following.
        for (int i = 0; i < 4; i++) begin
            base = wq.size();
            do_start();
            send_byte(lt[i].len[15:8], 0);
            send_byte(lt[i].len[7:0], 0);
            chk("len_done", 64'(done), 64'(lt[i].exp_done));
            chk("len_err", 64'(err), 64'(lt[i].exp_err));
            chk("len_busy", 64'(busy), 64'd0);
            chk("len_words", 64'(words_written), 64'd0);
            chk("len_no_write", 64'(wq.size() - base), 64'd0);
        end

        // Reference frame, bytes back-to-back with rx_valid held through the first WRITE.
        base   = wq.size();
        drops0 = ready_drops;
        do_start();
        for (int i = 0; i < 10; i++) begin
            send_byte(ex[i], 0);
            if (i == 5) begin
                chk("lat_we0", 64'(mem_we), 64'd1);
                chk("lat_addr0", 64'(mem_addr), 64'd0);
                chk("lat_data0", 64'(mem_wdata), 64'h3C080001);
            end
        end
        chk("lat_we1", 64'(mem_we), 64'd1);
        chk("lat_data1", 64'(mem_wdata), 64'h21090002);
        @(posedge clk); #1;
        chk("ex_done", 64'(done), 64'd1);
        chk("ex_busy", 64'(busy), 64'd0);
        chk("ex_words", 64'(words_written), 64'd2);
        chk("ex_ready_drops", 64'(ready_drops - drops0), 64'd1);
        exw = '{32'h3C080001, 32'h21090002};
        check_writes(base, exw);

        // start and rx_valid together: the byte must stay for LEN_HI, not be eaten.
        base = wq.size();
        rx_valid = 1'b1; rx_data = 8'h00;
        do_start();
        chk("sv_busy", 64'(busy), 64'd1);
        chk("sv_ready", 64'(rx_ready), 64'd1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        wait_done();
        chk("sv_done", 64'(done), 64'd1);
        chk("sv_words", 64'(words_written), 64'd1);
        exw = '{32'hDEADBEEF};
        check_writes(base, exw);

        for (int r = 0; r < 6; r++)
            run_load($urandom_range(12, 1), (r < 2) ? 0 : 4, r == 3);
        run_load(1024, 0, 1'b0);

        // Idle timeout mid-word: err rises on the 8th edge after the last accepted byte.
        base = wq.size();
        do_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            chk("tmo_early", 64'(err), 64'd0);
        end
        @(posedge clk); #1;
        chk("tmo_err", 64'(err), 64'd1);
        chk("tmo_busy", 64'(busy), 64'd0);
        chk("tmo_done", 64'(done), 64'd0);
        chk("tmo_words", 64'(words_written), 64'd0);
        chk("tmo_no_write", 64'(wq.size() - base), 64'd0);

        // Asynchronous reset in the middle of a word, then a fresh load from address 0.
        run_load(2, 1, 1'b0);
        do_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", 64'({rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_written}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_load(3, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
